// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU command sequencer and the ALU it drives:
// datapath widths, the 4-bit ALU opcode set, the sequencer state encoding
// and a helper that tells legal opcodes from reserved ones.
package alu_pkg;

    localparam int WIDTH = 32;
    localparam int REP_W = 4;

    localparam logic [3:0] OP_COPY_A = 4'b0000;
    localparam logic [3:0] OP_COPY_B = 4'b0001;
    localparam logic [3:0] OP_INC_A1 = 4'b0010;
    localparam logic [3:0] OP_DEC_A1 = 4'b0011;
    localparam logic [3:0] OP_INC_A4 = 4'b0100;
    localparam logic [3:0] OP_DEC_A4 = 4'b0101;
    localparam logic [3:0] OP_ADD    = 4'b0110;
    localparam logic [3:0] OP_SUB    = 4'b0111;
    localparam logic [3:0] OP_AND    = 4'b1000;
    localparam logic [3:0] OP_OR     = 4'b1001;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LD_A = 3'd1,
        ST_LD_B = 3'd2,
        ST_EXEC = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    // Opcodes above OR (1010..1111) are reserved.
    function automatic logic is_legal_op(input logic [3:0] op);
        return (op <= OP_OR);
    endfunction

endpackage

// File: rtl/ALU.sv
// ALU
// Purely combinational 32-bit ALU used by the command sequencer.
// Ports:
//   op1   - operand A
//   op2   - operand B
//   ALUOP - 4-bit opcode (see alu_pkg); reserved opcodes yield 0
//   data  - result, modulo 2^WIDTH
//   zero  - high when data is all zeros
module ALU
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       ALUOP,
    output logic [WIDTH-1:0] data,
    output logic             zero
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

    always_comb begin
        data = '0;
        case (ALUOP)
            OP_COPY_A: data = op1;
            OP_COPY_B: data = op2;
            OP_INC_A1: data = op1 + ONE;
            OP_DEC_A1: data = op1 - ONE;
            OP_INC_A4: data = op1 + FOUR;
            OP_DEC_A4: data = op1 - FOUR;
            OP_ADD:    data = op1 + op2;
            OP_SUB:    data = op1 - op2;
            OP_AND:    data = op1 & op2;
            OP_OR:     data = op1 | op2;
            default:   data = '0;
        endcase
    end

    assign zero = (data == '0);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Multi-cycle controller around the ALU. Accepts a command, collects
// operands A then B as two beats from the shared bus, runs 1..2^REP_W
// ALU passes (feeding the result back into A between passes) and returns
// result, zero flag and pass count on a response port.
//
// Handshakes: every port uses valid/ready; a transfer happens on a rising
// edge where both are high. Ready/valid outputs depend only on the state
// register (cmd_ready is additionally forced low while rst is high).
//
// Ports:
//   clk, rst                              - clock, synchronous active-high reset
//   cmd_valid/cmd_ready, cmd_op,
//   cmd_rep, cmd_stop_zero                - command port
//   bus_data/bus_valid/bus_ready          - operand beats (A then B)
//   res_valid/res_ready, res_data,
//   res_zero, res_err, res_iters          - response port
//   dbg_state                             - current FSM state
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int REP_W = alu_pkg::REP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [REP_W-1:0] cmd_rep,
    input  logic             cmd_stop_zero,
    input  logic [WIDTH-1:0] bus_data,
    input  logic             bus_valid,
    output logic             bus_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic             res_err,
    output logic [REP_W:0]   res_iters,
    output state_t           dbg_state
);

    localparam logic [REP_W-1:0] REM_ONE  = REP_W'(1);
    localparam logic [REP_W:0]   ITER_ONE = (REP_W + 1)'(1);

    state_t             state_q;
    logic [3:0]         op_q;
    logic               stop_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [REP_W-1:0]   rem_q;    // passes still allowed after the current one
    logic [REP_W:0]     iter_q;   // passes completed before the current one
    logic [WIDTH-1:0]   res_data_q;
    logic               res_zero_q;
    logic               res_err_q;
    logic [REP_W:0]     res_iters_q;

    logic [WIDTH-1:0]   alu_data;
    logic               alu_zero;

    ALU #(.WIDTH(WIDTH)) u_alu (
        .op1   (a_q),
        .op2   (b_q),
        .ALUOP (op_q),
        .data  (alu_data),
        .zero  (alu_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            stop_q      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            rem_q       <= '0;
            iter_q      <= '0;
            res_data_q  <= '0;
            res_zero_q  <= 1'b0;
            res_err_q   <= 1'b0;
            res_iters_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q   <= cmd_op;
                        rem_q  <= cmd_rep;
                        stop_q <= cmd_stop_zero;
                        iter_q <= '0;
                        if (is_legal_op(cmd_op)) begin
                            state_q <= ST_LD_A;
                        end else begin
                            // Reserved opcode: answer at once, no bus beats.
                            res_data_q  <= '0;
                            res_zero_q  <= 1'b0;
                            res_err_q   <= 1'b1;
                            res_iters_q <= '0;
                            state_q     <= ST_RESP;
                        end
                    end
                end
                ST_LD_A: begin
                    if (bus_valid) begin
                        a_q     <= bus_data;
                        state_q <= ST_LD_B;
                    end
                end
                ST_LD_B: begin
                    if (bus_valid) begin
                        b_q     <= bus_data;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // The zero-stop test applies to every pass, including the first.
                    if ((rem_q != '0) && !(stop_q && alu_zero)) begin
                        a_q    <= alu_data;
                        rem_q  <= rem_q - REM_ONE;
                        iter_q <= iter_q + ITER_ONE;
                    end else begin
                        res_data_q  <= alu_data;
                        res_zero_q  <= alu_zero;
                        res_err_q   <= 1'b0;
                        res_iters_q <= iter_q + ITER_ONE;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (res_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // cmd_ready is masked by rst so it reads 0 for the whole reset pulse.
    assign cmd_ready = (state_q == ST_IDLE) && !rst;
    assign bus_ready = (state_q == ST_LD_A) || (state_q == ST_LD_B);
    assign res_valid = (state_q == ST_RESP);
    assign res_data  = res_data_q;
    assign res_zero  = res_zero_q;
    assign res_err   = res_err_q;
    assign res_iters = res_iters_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic        zero;
    logic        err;
    logic [4:0]  iters;
  } resp_t;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [3:0]  cmd_rep;
  logic        cmd_stop_zero;
  logic [31:0] bus_data;
  logic        bus_valid;
  logic        bus_ready;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_zero;
  logic        res_err;
  logic [4:0]  res_iters;
  state_t      dbg_state;

  always #5 clk = ~clk;

  alu_cmd_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_rep       (cmd_rep),
    .cmd_stop_zero (cmd_stop_zero),
    .bus_data      (bus_data),
    .bus_valid     (bus_valid),
    .bus_ready     (bus_ready),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .res_zero      (res_zero),
    .res_err       (res_err),
    .res_iters     (res_iters),
    .dbg_state     (dbg_state)
  );

  int total = 0;
  int bad = 0;
  resp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a;
      4'd1: return b;
      4'd2: return a + 32'd1;
      4'd3: return a - 32'd1;
      4'd4: return a + 32'd4;
      4'd5: return a - 32'd4;
      4'd6: return a + b;
      4'd7: return a - b;
      4'd8: return a & b;
      4'd9: return a | b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic resp_t model(input logic [3:0] op, input int rep, input logic stop,
                                  input logic [31:0] a, input logic [31:0] b);
    resp_t r;
    logic [31:0] acc;
    logic [31:0] v;
    int passes;
    r = '0;
    if (op > 4'd9) begin
      r.err = 1'b1;
      return r;
    end
    acc = a;
    passes = 0;
    v = 32'd0;
    while (1) begin
      v = alu_ref(op, acc, b);
      passes++;
      if (passes > rep) break;
      if (stop && v == 32'd0) break;
      acc = v;
    end
    r.data  = v;
    r.zero  = (v == 32'd0);
    r.iters = 5'(passes);
    return r;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  resp_t mon_e;
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got=%h expected=none", res_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("res_data", res_data, mon_e.data);
        chk("res_zero", {31'd0, res_zero}, {31'd0, mon_e.zero});
        chk("res_err", {31'd0, res_err}, {31'd0, mon_e.err});
        chk("res_iters", {27'd0, res_iters}, {27'd0, mon_e.iters});
      end
    end
  end

  // ---------------- driver ----------------
  // Called and returns at posedge+#1.
  task automatic run_cmd(input logic [3:0] op, input logic [3:0] rep, input logic stop,
                         input logic [31:0] a, input logic [31:0] b, input int gap, input int hold);
    resp_t e;
    int n;
    int exp_n;
    e = model(op, int'(rep), stop, a, b);
    exp_q.push_back(e);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_rep = rep;
    cmd_stop_zero = stop;
    chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 4'($urandom);
    n = 0;
    if (!e.err) begin
      chk("bus_ready_lda", {31'd0, bus_ready}, 32'd1);
      bus_valid = 1'b1;
      bus_data = a;
      @(posedge clk); #1; n++;
      bus_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        bus_data = $urandom;
        chk("stall_ldb", {30'd0, bus_ready, res_valid}, 32'd2);
        @(posedge clk); #1; n++;
      end
      bus_valid = 1'b1;
      bus_data = b;
      @(posedge clk); #1; n++;
      bus_valid = 1'b0;
      bus_data = $urandom;
    end
    while (!res_valid && n < 200) begin
      if (e.err) chk("bus_ready_illegal", {31'd0, bus_ready}, 32'd0);
      @(posedge clk); #1; n++;
    end
    if (!res_valid) begin
      total++;
      bad++;
      $display("FAIL resp_timeout: got=no_res_valid expected=res_valid op=%0d", op);
      return;
    end
    exp_n = e.err ? 0 : (2 + gap + int'(e.iters));
    chk("latency", n, exp_n);
    for (int h = 0; h < hold; h++) begin
      chk("hold_data", res_data, e.data);
      chk("hold_flags", {28'd0, cmd_ready, res_valid, res_zero, res_err},
          {28'd0, 1'b0, 1'b1, e.zero, e.err});
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("idle_after_resp", {30'd0, cmd_ready, res_valid}, 32'd2);
    chk("res_data_held", res_data, e.data);
  endtask

  task automatic reset_mid_exec();
    int seen;
    cmd_valid = 1'b1;
    cmd_op = OP_INC_A1;
    cmd_rep = 4'd10;
    cmd_stop_zero = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    bus_valid = 1'b1;
    bus_data = 32'h100;
    @(posedge clk); #1;
    bus_data = 32'h200;
    @(posedge clk); #1;
    bus_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("in_exec", {29'd0, dbg_state}, {29'd0, ST_EXEC});
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    chk("rst_ready", {29'd0, cmd_ready, bus_ready, res_valid}, 32'd0);
    chk("rst_data", res_data, 32'd0);
    chk("rst_flags", {25'd0, res_zero, res_err, res_iters}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    seen = 0;
    repeat (15) begin
      if (res_valid) seen++;
      @(posedge clk); #1;
    end
    chk("no_resp_after_rst", seen, 0);
  endtask

  // ---------------- main ----------------
  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_rep = '0;
    cmd_stop_zero = 1'b0;
    bus_data = '0;
    bus_valid = 1'b0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("reset_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    chk("reset_valids", {30'd0, bus_ready, res_valid}, 32'd0);
    chk("reset_data", res_data, 32'd0);
    chk("reset_flags", {25'd0, res_zero, res_err, res_iters}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_reset_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;

    run_cmd(OP_ADD,    4'd0,  1'b0, 32'hFFFF0000, 32'h0000FFFF, 0, 0);
    run_cmd(OP_INC_A4, 4'd3,  1'b0, 32'h0,        32'h1234,     0, 0);
    run_cmd(OP_INC_A1, 4'd0,  1'b0, 32'hFFFFFFFF, 32'h0,        0, 0);
    run_cmd(OP_DEC_A1, 4'd15, 1'b1, 32'd5,        32'h0,        0, 0);
    run_cmd(OP_SUB,    4'd2,  1'b0, 32'hFFFFFFFC, 32'hFFFFFFFC, 0, 0);
    run_cmd(4'b1100,   4'd5,  1'b0, 32'h0,        32'h0,        0, 1);
    run_cmd(OP_OR,     4'd0,  1'b0, 32'hFFFFFFFC, 32'hF000000C, 0, 0);
    run_cmd(OP_ADD,    4'd1,  1'b0, $urandom,     $urandom,     3, 5);
    run_cmd(OP_COPY_B, 4'd15, 1'b0, $urandom,     $urandom,     0, 0);

    reset_mid_exec();

    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra;
      ra = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 12)) : $urandom;
      run_cmd(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              ra, $urandom, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
